// File: rtl/io_proto_pkg.sv
// io_proto_pkg
// Shared definitions for the byte-serial CPU IO protocol as seen from the
// memory side:
//   - op codes carried on op when op_valid pulses
//   - the load stall marker
//   - the byte count of a word
//   - the responder FSM state type
// Consumers: io_memory_responder, resp_word_mem.
package io_proto_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_PCLOAD = 2'b11;

  localparam logic [7:0] STALL_MARKER   = 8'hFF;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_INST  = 3'd1,
    ST_WAIT_OP    = 3'd2,
    ST_RECV_WORD  = 3'd3,
    ST_WAIT_STALL = 3'd4,
    ST_SEND_WORD  = 3'd5
  } resp_state_e;

  // Byte 'sel' of a 32-bit word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/resp_word_mem.sv
// resp_word_mem
// MEM_WORDS x 32 word array: synchronous write, asynchronous read, with a
// byte-select mux on the read side. Contents are not reset.
// Ports:
//   clk       in   clock
//   we        in   write enable (word write at idx)
//   idx       in   word index for both read and write
//   wdata     in   write word
//   byte_sel  in   byte of mem[idx] presented on rbyte
//   rbyte     out  selected read byte (combinational)
module resp_word_mem
  import io_proto_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [1:0]    byte_sel,
  output logic [7:0]    rbyte
);

  logic [31:0] mem_q [MEM_WORDS];

  // Word write port; the array intentionally has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rbyte = word_byte(mem_q[idx], byte_sel);

endmodule

// File: rtl/io_memory_responder.sv
// io_memory_responder
// Memory-side partner of the byte-serial CPU IO controller. Holds a word
// memory and the program counter, serves instructions LSB-first, captures
// address/data byte pairs for store / load / pc_load, and returns load data
// after the stall marker.
// Ports:
//   clk, rst (async, active-low)
//   frame_start, op_valid, op[1:0]     controller handshakes
//   addr_byte_in, data_byte_in         bytes from the controller
//   data_byte_out                      registered byte to the controller
//   busy, pc[31:0]                     status (registered)
//   load_en, load_addr, load_data      host preload, honoured in IDLE
// Optional: RESP_ADDR_CHECK_EN adds a sticky 'err' output; accesses at or
// above 4*MEM_WORDS set it, out-of-range writes are dropped and
// out-of-range reads return 8'h00. Without it addresses wrap.
module io_memory_responder
  import io_proto_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [7:0]  addr_byte_in,
  input  logic [7:0]  data_byte_in,
  output logic [7:0]  data_byte_out,
  output logic        busy,
  output logic [31:0] pc,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
`ifdef RESP_ADDR_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(MEM_WORDS);

  resp_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  dout_q, dout_d;
  logic        busy_q, busy_d;

  logic [31:0] addr_cap_s, data_cap_s;
  logic [31:0] mem_addr_s, mem_wdata_s;
  logic [1:0]  mem_sel_s;
  logic        mem_we_s, mem_we_eff_s, access_s;
  logic [7:0]  mem_byte_s, rd_byte_s;
  logic        unused_s;

  // Current capture registers with this cycle's byte pair merged in.
  always_comb begin
    addr_cap_s = addr_q;
    data_cap_s = data_q;
    addr_cap_s[{cnt_q[1:0], 3'b000} +: 8] = addr_byte_in;
    data_cap_s[{cnt_q[1:0], 3'b000} +: 8] = data_byte_in;
  end

  // Memory port steering: one address serves reads and writes, so the
  // fetch on frame_start wins over everything (it also aborts any write).
  always_comb begin
    mem_addr_s  = pc_q;
    mem_wdata_s = load_data;
    mem_sel_s   = 2'd0;
    mem_we_s    = 1'b0;
    access_s    = 1'b0;
    if (frame_start) begin
      access_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            mem_addr_s = load_addr;
            mem_we_s   = 1'b1;
            access_s   = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        ST_SEND_INST: mem_sel_s = cnt_q[1:0];
        ST_RECV_WORD: begin
          if ((cnt_q[1:0] == 2'd3) && (op_q == OP_STORE)) begin
            mem_addr_s  = addr_cap_s;
            mem_wdata_s = data_cap_s;
            mem_we_s    = 1'b1;
            access_s    = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        ST_WAIT_STALL: begin
          mem_addr_s = addr_q;
          access_s   = (addr_byte_in == STALL_MARKER);
        end
        ST_SEND_WORD: begin
          mem_addr_s = addr_q;
          mem_sel_s  = cnt_q[1:0];
        end
        default: mem_we_s = 1'b0;
      endcase
    end
  end

  resp_word_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk      (clk),
    .we       (mem_we_eff_s),
    .idx      (mem_addr_s[AW+1:2]),
    .wdata    (mem_wdata_s),
    .byte_sel (mem_sel_s),
    .rbyte    (mem_byte_s)
  );

`ifdef RESP_ADDR_CHECK_EN
  logic oor_s;
  logic err_q, err_d;

  assign oor_s        = |mem_addr_s[31:AW+2];
  assign mem_we_eff_s = mem_we_s & ~oor_s;
  assign rd_byte_s    = oor_s ? 8'h00 : mem_byte_s;
  assign err_d        = err_q | (access_s & oor_s);
  assign err          = err_q;
  assign unused_s     = ^mem_addr_s[1:0];

  // Sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign mem_we_eff_s = mem_we_s;
  assign rd_byte_s    = mem_byte_s;
  assign unused_s     = ^{mem_addr_s[31:AW+2], mem_addr_s[1:0], access_s};
`endif

  // Next-state and datapath. Byte 0 of a word is latched on the entry edge,
  // so cnt counts bytes already presented (1..4) while sending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    dout_d  = dout_q;
    if (frame_start) begin
      state_d = ST_SEND_INST;
      cnt_d   = 3'd1;
      dout_d  = rd_byte_s;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_SEND_INST, ST_SEND_WORD: begin
          if (cnt_q == 3'd4) begin
            dout_d = 8'h00;
            cnt_d  = 3'd0;
            if (state_q == ST_SEND_INST) begin
              state_d = ST_WAIT_OP;
            end else begin
              pc_d    = pc_q + 32'd4;
              state_d = ST_IDLE;
            end
          end else begin
            dout_d = rd_byte_s;
            cnt_d  = cnt_q + 3'd1;
          end
        end
        ST_WAIT_OP: begin
          if (op_valid) begin
            if (op == OP_NONE) begin
              pc_d    = pc_q + 32'd4;
              state_d = ST_IDLE;
            end else begin
              op_d    = op;
              cnt_d   = 3'd0;
              state_d = ST_RECV_WORD;
            end
          end else begin
            state_d = ST_WAIT_OP;
          end
        end
        ST_RECV_WORD: begin
          addr_d = addr_cap_s;
          data_d = data_cap_s;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d = 3'd0;
            case (op_q)
              OP_STORE: begin
                pc_d    = pc_q + 32'd4;
                state_d = ST_IDLE;
              end
              OP_LOAD:   state_d = ST_WAIT_STALL;
              OP_PCLOAD: begin
                pc_d    = addr_cap_s;
                state_d = ST_IDLE;
              end
              default:   state_d = ST_IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_WAIT_STALL: begin
          if (addr_byte_in == STALL_MARKER) begin
            dout_d  = rd_byte_s;
            cnt_d   = 3'd1;
            state_d = ST_SEND_WORD;
          end else begin
            state_d = ST_WAIT_STALL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      op_q    <= OP_NONE;
      dout_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign data_byte_out = dout_q;
  assign busy          = busy_q;
  assign pc            = pc_q;

endmodule

// File: tb/tb_io_memory_responder.sv
module tb_io_memory_responder;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  addr_byte_in = 8'h00;
  logic [7:0]  data_byte_in = 8'h00;
  logic [7:0]  data_byte_out;
  logic        busy;
  logic [31:0] pc;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
`ifdef RESP_ADDR_CHECK_EN
  logic        err;
`endif

  io_memory_responder #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dut (
`ifdef RESP_ADDR_CHECK_EN
    .err           (err),
`endif
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .op_valid      (op_valid),
    .op            (op),
    .addr_byte_in  (addr_byte_in),
    .data_byte_in  (data_byte_in),
    .data_byte_out (data_byte_out),
    .busy          (busy),
    .pc            (pc),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mmem [MEM_WORDS];
  logic [31:0] mpc;
  logic        merr;
  int checks = 0;
  int errors = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(MEM_WORDS));
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef RESP_ADDR_CHECK_EN
    return a < 32'(4 * MEM_WORDS);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_range(a) ? mmem[widx(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] rnd_addr();
`ifdef RESP_ADDR_CHECK_EN
    return 32'($urandom_range(0, 4 * MEM_WORDS - 1));
`else
    return $urandom;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (in_range(a)) mmem[widx(a)] = d;
  endtask

  // Checks the four instruction bytes and the idle byte afterwards.
  task automatic inst_bytes(input string tag);
    logic [31:0] w;
    w = model_read(mpc);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_byte"}, {24'h0, data_byte_out}, {24'h0, w[8*i +: 8]});
      chk({tag, "_busy"}, {31'h0, busy}, 32'd1);
      tick();
    end
    chk({tag, "_after"}, {24'h0, data_byte_out}, 32'h0);
  endtask

  task automatic fetch(input string tag);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    inst_bytes(tag);
  endtask

  task automatic op_none();
    op_valid = 1'b1; op = 2'b00;
    tick();
    op_valid = 1'b0;
    mpc = mpc + 32'd4;
    chk("none_pc", pc, mpc);
    chk("none_busy", {31'h0, busy}, 32'd0);
  endtask

  task automatic send_pairs(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
    op_valid = 1'b1; op = code;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_byte_in = a[8*i +: 8];
      data_byte_in = d[8*i +: 8];
      tick();
    end
    addr_byte_in = 8'h00; data_byte_in = 8'h00;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    send_pairs(2'b01, a, d);
    if (in_range(a)) mmem[widx(a)] = d;
    else merr = 1'b1;
    mpc = mpc + 32'd4;
    chk("store_pc", pc, mpc);
    chk("store_busy", {31'h0, busy}, 32'd0);
  endtask

  task automatic pcload(input logic [31:0] a);
    send_pairs(2'b11, a, $urandom);
    mpc = a;
    chk("pcload_pc", pc, mpc);
  endtask

  task automatic load(input logic [31:0] a, input int idles);
    logic [31:0] w;
    send_pairs(2'b10, a, $urandom);
    for (int i = 0; i < idles; i++) begin
      addr_byte_in = 8'($urandom_range(0, 254));
      tick();
      chk("stall_hold", {24'h0, data_byte_out}, 32'h0);
    end
    addr_byte_in = 8'hFF;
    tick();
    addr_byte_in = 8'h00;
    if (!in_range(a)) merr = 1'b1;
    w = model_read(a);
    for (int i = 0; i < 4; i++) begin
      chk("load_byte", {24'h0, data_byte_out}, {24'h0, w[8*i +: 8]});
      tick();
    end
    chk("load_after", {24'h0, data_byte_out}, 32'h0);
    chk("load_busy", {31'h0, busy}, 32'd0);
    mpc = mpc + 32'd4;
    chk("load_pc", pc, mpc);
  endtask

  initial begin
    logic [31:0] ta, td, w;
    merr = 1'b0;
    mpc  = RESET_PC;

    // Reset state
    repeat (2) tick();
    chk("rst_dout", {24'h0, data_byte_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    rst = 1'b1;
    tick();

    for (int i = 0; i < MEM_WORDS; i++) preload(32'(4 * i), $urandom);
    preload(32'h0, 32'h8C22_0004);

    // Directed scenarios
    fetch("fetch0");
    op_none();
    fetch("fetch1");
    store(32'h10, 32'hDEAD_BEEF);
    fetch("fetch2");
    load(32'h10, 3);
    fetch("fetch3");
    pcload(32'h20);
    fetch("fetch_mem8");
    op_none();

    // frame_start together with load_en: preload is ignored
    frame_start = 1'b1; load_en = 1'b1; load_addr = mpc; load_data = ~mmem[widx(mpc)];
    tick();
    frame_start = 1'b0; load_en = 1'b0;
    inst_bytes("fs_vs_load");
    op_none();

    // Abort during RECV_WORD byte 2
    ta = rnd_addr();
    td = ~model_read(ta);
    fetch("abort_pre");
    op_valid = 1'b1; op = 2'b01;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr_byte_in = ta[8*i +: 8]; data_byte_in = td[8*i +: 8];
      tick();
    end
    addr_byte_in = ta[23:16]; data_byte_in = td[23:16]; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; addr_byte_in = 8'h00; data_byte_in = 8'h00;
    chk("abort_pc", pc, mpc);
    inst_bytes("abort_resync");
    load(ta, 1);

`ifndef RESP_ADDR_CHECK_EN
    // pc wraps at 2^32
    fetch("wrap_pre");
    pcload(32'hFFFF_FFFC);
    fetch("wrap_fetch");
    op_none();
`endif

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      fetch("rnd_fetch");
      case ($urandom_range(0, 3))
        0: op_none();
        1: store(rnd_addr(), $urandom);
        2: load(rnd_addr(), int'($urandom_range(0, 3)));
        default: pcload(rnd_addr());
      endcase
    end

    // Reset in the middle of SEND_WORD
    fetch("rstmid_fetch");
    ta = rnd_addr();
    send_pairs(2'b10, ta, 32'h0);
    addr_byte_in = 8'hFF;
    tick();
    addr_byte_in = 8'h00;
    w = model_read(ta);
    chk("rstmid_b0", {24'h0, data_byte_out}, {24'h0, w[7:0]});
    tick();
    chk("rstmid_b1", {24'h0, data_byte_out}, {24'h0, w[15:8]});
    rst = 1'b0;
    #1;
    chk("rstmid_dout", {24'h0, data_byte_out}, 32'h0);
    chk("rstmid_pc", pc, RESET_PC);
    chk("rstmid_busy", {31'h0, busy}, 32'd0);
    tick();
    rst = 1'b1;
    mpc = RESET_PC;
    merr = 1'b0;
    tick();
    fetch("post_rst");
    op_none();

`ifdef RESP_ADDR_CHECK_EN
    chk("err_clear", {31'h0, err}, 32'd0);
    fetch("oor_pre");
    store(32'h100, 32'hCAFE_F00D);
    chk("err_set", {31'h0, err}, 32'd1);
    fetch("oor_load_pre");
    load(32'h100, 2);
    fetch("alias_pre");
    load(32'h0, 0);
    chk("err_sticky", {31'h0, err}, {31'h0, merr});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
